// File: rtl/lgv8_pipe_pkg.sv
// Shared types and constants for the LEGv8 pipeline sequencer.
package lgv8_pipe_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam logic [4:0] XZR_IDX = 5'd31;

  // One bit per pipeline register, IF_ID down to MEM_WB.
  typedef struct packed {
    logic if_id;
    logic id_ex;
    logic ex_mem;
    logic mem_wb;
  } pipe_en_t;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Stall and flush performance counters, wrapping modulo 2^CNT_W.
module pipe_perf_cnt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_inc,
  input  logic             flush_inc,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc) stall_cnt <= stall_cnt + 1'b1;
      if (flush_inc) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// LEGv8 5-stage pipeline sequencer: memory wait, taken-branch flush and
// load-use stall, with performance counters and a sticky timeout flag.
module pipe_hazard_ctrl
  import lgv8_pipe_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_ex_mem_read,
  input  logic [4:0]       id_ex_rd,
  input  logic [4:0]       if_id_rs1,
  input  logic [4:0]       if_id_rs2,
  input  logic             ex_mem_branch,
  input  logic             ex_mem_zero,
  input  logic             ex_mem_mem_read,
  input  logic             ex_mem_mem_write,
  input  logic             dmem_ready,
  output logic             dmem_req,
  output logic             pc_en,
  output logic             pc_sel_branch,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic             err_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt, wait_nxt;
  logic       err_nxt;
  logic       mem_acc, taken, lu_hit, frozen;
  logic       stall_inc, flush_inc;
  pipe_en_t   en, flush;

  assign mem_acc = ex_mem_mem_read | ex_mem_mem_write;
  assign taken   = ex_mem_branch & ex_mem_zero;
  assign lu_hit  = id_ex_mem_read && (id_ex_rd != XZR_IDX) &&
                   ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));

  always_comb begin
    state_nxt     = state;
    wait_nxt      = wait_cnt;
    err_nxt       = err_timeout;
    en            = '1;
    flush         = '0;
    pc_en         = 1'b1;
    pc_sel_branch = 1'b0;
    dmem_req      = 1'b0;
    frozen        = 1'b0;
    flush_inc     = 1'b0;

    case (state)
      RUN: begin
        dmem_req = mem_acc;
        if (mem_acc && !dmem_ready) begin
          frozen    = 1'b1;
          state_nxt = MEM_WAIT;
          wait_nxt  = 8'd1;
        end
      end
      MEM_WAIT: begin
        dmem_req = 1'b1;
        if (!dmem_ready) begin
          frozen = 1'b1;
          if (wait_cnt != 8'd255) wait_nxt = wait_cnt + 8'd1;
        end else begin
          state_nxt = RUN;
          wait_nxt  = '0;
        end
      end
      default: state_nxt = RUN;
    endcase

    if (frozen) begin
      pc_en         = 1'b0;
      en            = '0;
      en.mem_wb     = 1'b1;
      flush.mem_wb  = 1'b1;
      if (wait_nxt >= TIMEOUT_CNT) err_nxt = 1'b1;
    end else if (taken) begin
      // Branch squashes the load-use victim, so no stall alongside it.
      pc_sel_branch = 1'b1;
      flush.if_id   = 1'b1;
      flush.id_ex   = 1'b1;
      flush.ex_mem  = 1'b1;
      flush_inc     = 1'b1;
    end else if (lu_hit) begin
      pc_en       = 1'b0;
      en.if_id    = 1'b0;
      flush.id_ex = 1'b1;
    end

    // Reset overrides everything combinationally, independent of the clock.
    if (!rst_n) begin
      en            = '0;
      flush         = '1;
      pc_en         = 1'b0;
      pc_sel_branch = 1'b0;
      dmem_req      = 1'b0;
      flush_inc     = 1'b0;
    end
  end

  assign stall_inc = rst_n & ~pc_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      wait_cnt    <= '0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_nxt;
      err_timeout <= err_nxt;
    end
  end

  assign if_id_en     = en.if_id;
  assign id_ex_en     = en.id_ex;
  assign ex_mem_en    = en.ex_mem;
  assign mem_wb_en    = en.mem_wb;
  assign if_id_flush  = flush.if_id;
  assign id_ex_flush  = flush.id_ex;
  assign ex_mem_flush = flush.ex_mem;
  assign mem_wb_flush = flush.mem_wb;

  pipe_perf_cnt #(
    .CNT_W(CNT_W)
  ) u_perf (
    .clk      (clk),
    .rst_n    (rst_n),
    .stall_inc(stall_inc),
    .flush_inc(flush_inc),
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencer for the 5-stage LEGv8 core. Drives enable/flush of the IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers and the PC.
- Resolves three hazards: load-use stall, taken-branch flush (resolved in MEM), and multi-cycle data-memory wait via a req/ready handshake.
- Keeps stall/flush performance counters and a sticky memory-timeout error flag.

Parameters:
- CNT_W, 32, width of the performance counters.
- MEM_TIMEOUT, 16, maximum MEM_WAIT cycles before err_timeout sets (legal range 1..255).

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_ex_mem_read  in  1  instruction in EX is a load (LDUR).
- id_ex_rd  in  5  destination register of the instruction in EX.
- if_id_rs1  in  5  source reg 1 of the instruction in ID.
- if_id_rs2  in  5  source reg 2 of the instruction in ID.
- ex_mem_branch  in  1  instruction in MEM is CBZ/B.
- ex_mem_zero  in  1  Zero flag latched with that instruction.
- ex_mem_mem_read  in  1  instruction in MEM is a load.
- ex_mem_mem_write  in  1  instruction in MEM is a store.
- dmem_ready  in  1  data memory completes the access this cycle.
- dmem_req  out  1  data-memory access request.
- pc_en  out  1  PC write enable.
- pc_sel_branch  out  1  select ADD_result as next PC.
- if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  register load enables.
- if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  load a bubble (all controls 0).
- err_timeout  out  1  sticky: a memory wait exceeded MEM_TIMEOUT.
- stall_cnt  out  CNT_W  cycles in which pc_en was 0 (excluding reset).
- flush_cnt  out  CNT_W  number of taken branches.

Behaviour:
- State machine: RUN, MEM_WAIT. The state register, wait counter (8 bit), err_timeout and both counters are flops. All other outputs are combinational from the state and inputs.
- Reset (rst_n=0, async):
  - State goes to RUN; wait counter, counters and err_timeout clear to 0.
  - While rst_n is low: all *_en=0, all *_flush=1, pc_en=0, pc_sel_branch=0, dmem_req=0.
- Definitions:
  - mem_acc = ex_mem_mem_read | ex_mem_mem_write.
  - taken = ex_mem_branch & ex_mem_zero.
  - lu_hit = id_ex_mem_read & (id_ex_rd != 31) & (id_ex_rd == if_id_rs1 | id_ex_rd == if_id_rs2). X31 is XZR and never hazards.
- Default (no hazard): every en=1, every flush=0, pc_sel_branch=0.
- Priority: memory wait > taken branch > load-use.
- Memory handshake:
  - dmem_req = mem_acc in RUN, and 1 throughout MEM_WAIT.
  - RUN with mem_acc & dmem_ready: zero-latency, no stall.
  - RUN with mem_acc & !dmem_ready: freeze this cycle (pc_en, if_id_en, id_ex_en, ex_mem_en = 0; mem_wb_flush=1, mem_wb_en=1). Next state MEM_WAIT; wait counter = 1.
  - MEM_WAIT with !dmem_ready: same freeze; wait counter increments and saturates at 255. When the counter reaches MEM_TIMEOUT, err_timeout sets and stays set until reset. The wait itself continues.
  - MEM_WAIT with dmem_ready: default enables this cycle (the access retires into MEM_WB). Next state RUN; wait counter clears.
- Taken branch (RUN, no stall this cycle):
  - pc_sel_branch=1, pc_en=1.
  - if_id_flush=1, id_ex_flush=1, ex_mem_flush=1.
  - flush_cnt increments.
  - Branch and memory access in the same MEM instruction cannot occur. If both are ever asserted, the memory wait is serviced first and the branch is taken on the ready cycle.
- Load-use (only if no memory stall and not taken): pc_en=0, if_id_en=0, id_ex_flush=1. EX_MEM and MEM_WB advance. Exactly one bubble per hit.
- Taken branch with lu_hit: the flush wins, no stall (the dependent instruction is squashed).
- stall_cnt increments on every cycle with rst_n=1 and pc_en=0. Both counters wrap modulo 2^CNT_W.
- Reset asserted mid-MEM_WAIT: return to RUN immediately; dmem_req drops asynchronously.

Decomposition:
- Shared package lgv8_pipe_pkg: state enum {RUN, MEM_WAIT}, constant XZR_IDX=5'd31, pipeline-enable bundle typedef.
- One natural sub-module: pipe_perf_cnt (two CNT_W counters with increment strobes).
- The FSM and hazard logic stay in the top module.

Test Plan:
- Reset release, no hazards, mem_acc=0 → all en=1, all flush=0, stall_cnt=0, flush_cnt=0 over 10 cycles.
- Load-use: id_ex_mem_read=1, id_ex_rd=5, if_id_rs2=5 for 1 cycle → pc_en=0, if_id_en=0, id_ex_flush=1 that cycle; stall_cnt=1. Repeat with id_ex_rd=31 → no stall.
- Branch: ex_mem_branch=1, ex_mem_zero=1 → pc_sel_branch=1; IF_ID/ID_EX/EX_MEM flush=1 for 1 cycle; flush_cnt=1. With zero=0 → no flush.
- Memory wait: ex_mem_mem_read=1, dmem_ready low 3 cycles then high → dmem_req=1 for 4 cycles; pc_en=0 and mem_wb_flush=1 for 3 cycles; stall_cnt=3; state back to RUN.
- Timeout: MEM_TIMEOUT=4, dmem_ready low 6 cycles → err_timeout rises in the 4th wait cycle and stays 1 after ready and subsequent traffic.
- Async reset during MEM_WAIT (mid-cycle) → dmem_req=0 without a clock edge; state RUN, counters 0, err_timeout 0 after release.
